// File: rtl/eth_ingress_adapter_pkg.sv
// Shared definitions for the Ethernet ingress adapter: arg3 field layout, FSM encoding
// and the default packet length limit.
package eth_ingress_adapter_pkg;

  localparam int DEFAULT_MAX_PKT_FLITS = 24;

  localparam int DATA_W  = 512;
  localparam int EMPTY_W = 6;
  localparam int ARG3_W  = 8;
  localparam int STAT_W  = 32;
  localparam int CNT_W   = 16;

  localparam int ARG3_SOP       = 0;
  localparam int ARG3_EOP       = 1;
  localparam int ARG3_EMPTY_LSB = 2;
  localparam int ARG3_EMPTY_MSB = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PKT  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  function automatic logic [ARG3_W-1:0] pack_arg3(input logic [EMPTY_W-1:0] empty,
                                                  input logic eop,
                                                  input logic sop);
    logic [ARG3_W-1:0] a;
    a = '0;
    a[ARG3_SOP] = sop;
    a[ARG3_EOP] = eop;
    a[ARG3_EMPTY_MSB:ARG3_EMPTY_LSB] = empty;
    return a;
  endfunction

endpackage

// File: rtl/eth_ingress_adapter_stats_counter.sv
// Wrapping 32-bit event counter used for every ingress statistic.
module ingress_stats_counter
  import eth_ingress_adapter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  output logic [STAT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc) begin
      count <= count + STAT_W'(1);
    end
  end

endmodule

// File: rtl/eth_ingress_adapter.sv
// Ethernet MAC-to-eth ingress adapter: re-frames the unthrottled MAC flit stream, drops
// packets refused at SOP and repairs framing. ETH_INGRESS_LEN_CHECK_EN enables truncation.
//
// state | meaning
// IDLE  | between packets; non-SOP flits are orphans
// PKT   | forwarding an accepted packet
// DROP  | discarding the rest of a refused or cut-off packet
module eth_ingress_adapter
  import eth_ingress_adapter_pkg::*;
#(
  parameter int MAX_PKT_FLITS = DEFAULT_MAX_PKT_FLITS
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               in_valid,
  input  logic               in_sop,
  input  logic               in_eop,
  input  logic [EMPTY_W-1:0] in_empty,
  input  logic [DATA_W-1:0]  in_data,
  output logic               eth_tx,
  output logic [DATA_W-1:0]  eth_tx_data,
  output logic [ARG3_W-1:0]  eth_tx_arg3,
  input  logic               eth_tx_full,
  output logic [STAT_W-1:0]  stats_pkt_in,
  output logic [STAT_W-1:0]  stats_pkt_out,
  output logic [STAT_W-1:0]  stats_drop,
  output logic [STAT_W-1:0]  stats_err,
  output logic [STAT_W-1:0]  stats_trunc
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   flit_cnt_q, flit_cnt_d;
  logic [CNT_W-1:0]   cnt_next_body;
  logic               sop_flit, body_flit, trunc;

  logic               emit, o_sop, o_eop;
  logic [EMPTY_W-1:0] o_empty;
  logic               inc_pkt_in, inc_pkt_out, inc_drop, inc_err, inc_trunc;

  assign sop_flit      = in_valid & in_sop;
  assign body_flit     = in_valid & ~in_sop;
  assign cnt_next_body = flit_cnt_q + CNT_W'(1);

`ifdef ETH_INGRESS_LEN_CHECK_EN
  // A flit that would make the packet MAX_PKT_FLITS long without carrying EOP closes it.
  assign trunc = ((state_q == ST_PKT) && body_flit && !in_eop &&
                  (cnt_next_body == CNT_W'(MAX_PKT_FLITS))) ||
                 ((state_q != ST_PKT) && sop_flit && !eth_tx_full && !in_eop &&
                  (MAX_PKT_FLITS == 1));
`else
  assign trunc = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= ST_IDLE;
      flit_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      flit_cnt_q <= flit_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DROP: begin
        if (sop_flit) begin
          if (in_eop)                     state_d = ST_IDLE;
          else if (eth_tx_full || trunc)  state_d = ST_DROP;
          else                            state_d = ST_PKT;
        end else if ((state_q == ST_DROP) && body_flit && in_eop) begin
          state_d = ST_IDLE;
        end
      end
      ST_PKT: begin
        if (sop_flit) begin
          state_d = in_eop ? ST_IDLE : ST_DROP;
        end else if (body_flit) begin
          if (in_eop)     state_d = ST_IDLE;
          else if (trunc) state_d = ST_DROP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    emit       = 1'b0;
    o_sop      = 1'b0;
    o_eop      = 1'b0;
    o_empty    = '0;
    flit_cnt_d = flit_cnt_q;
    inc_drop   = 1'b0;
    inc_err    = 1'b0;
    inc_trunc  = 1'b0;
    inc_pkt_in = sop_flit;
    case (state_q)
      ST_IDLE, ST_DROP: begin
        if (sop_flit) begin
          if (eth_tx_full) begin
            inc_drop = 1'b1;
          end else begin
            emit       = 1'b1;
            o_sop      = 1'b1;
            o_eop      = in_eop | trunc;
            o_empty    = trunc ? '0 : in_empty;
            flit_cnt_d = CNT_W'(1);
            inc_trunc  = trunc;
          end
        end else if ((state_q == ST_IDLE) && body_flit) begin
          inc_err = 1'b1;
        end
      end
      ST_PKT: begin
        if (sop_flit) begin
          // Missing EOP: this flit becomes the closing flit of the open packet.
          emit    = 1'b1;
          o_eop   = 1'b1;
          inc_err = 1'b1;
        end else if (body_flit) begin
          emit       = 1'b1;
          o_eop      = in_eop | trunc;
          o_empty    = trunc ? '0 : in_empty;
          flit_cnt_d = cnt_next_body;
          inc_trunc  = trunc;
        end
      end
      default: ;
    endcase
  end

  assign inc_pkt_out = emit & o_eop;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      eth_tx      <= 1'b0;
      eth_tx_data <= '0;
      eth_tx_arg3 <= '0;
    end else begin
      eth_tx <= emit;
      if (emit) begin
        eth_tx_data <= in_data;
        eth_tx_arg3 <= pack_arg3(o_empty, o_eop, o_sop);
      end
    end
  end

  ingress_stats_counter u_cnt_pkt_in (
    .clk(Clk), .rst(Rst), .inc(inc_pkt_in), .count(stats_pkt_in)
  );
  ingress_stats_counter u_cnt_pkt_out (
    .clk(Clk), .rst(Rst), .inc(inc_pkt_out), .count(stats_pkt_out)
  );
  ingress_stats_counter u_cnt_drop (
    .clk(Clk), .rst(Rst), .inc(inc_drop), .count(stats_drop)
  );
  ingress_stats_counter u_cnt_err (
    .clk(Clk), .rst(Rst), .inc(inc_err), .count(stats_err)
  );

`ifdef ETH_INGRESS_LEN_CHECK_EN
  ingress_stats_counter u_cnt_trunc (
    .clk(Clk), .rst(Rst), .inc(inc_trunc), .count(stats_trunc)
  );
`else
  logic unused_trunc;
  assign unused_trunc = inc_trunc;
  assign stats_trunc  = '0;
`endif

endmodule

// File: tb/tb_eth_ingress_adapter.sv
// Directed self-checking bench for eth_ingress_adapter; expectations follow the
// ETH_INGRESS_LEN_CHECK_EN setting of the build.
module tb_eth_ingress_adapter;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         in_valid, in_sop, in_eop;
  logic [5:0]   in_empty;
  logic [511:0] in_data;
  logic         eth_tx;
  logic [511:0] eth_tx_data;
  logic [7:0]   eth_tx_arg3;
  logic         eth_tx_full;
  logic [31:0]  stats_pkt_in, stats_pkt_out, stats_drop, stats_err, stats_trunc;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  eth_ingress_adapter dut (
    .Clk(Clk), .Rst(Rst),
    .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_empty(in_empty), .in_data(in_data),
    .eth_tx(eth_tx), .eth_tx_data(eth_tx_data), .eth_tx_arg3(eth_tx_arg3),
    .eth_tx_full(eth_tx_full),
    .stats_pkt_in(stats_pkt_in), .stats_pkt_out(stats_pkt_out),
    .stats_drop(stats_drop), .stats_err(stats_err), .stats_trunc(stats_trunc)
  );

  // Present one input cycle, then sample the registered result 1 ns after the edge.
  task automatic drive(input logic v, input logic s, input logic e,
                       input logic [5:0] emp, input logic full, input logic [511:0] d);
    in_valid = v; in_sop = s; in_eop = e; in_empty = emp; eth_tx_full = full; in_data = d;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 0; in_sop = 0; in_eop = 0; in_empty = 0; eth_tx_full = 0; in_data = '0;
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    Rst = 1'b1;
    #1;
    checks++;
    if (eth_tx !== 1'b0 || eth_tx_arg3 !== 8'h00 || eth_tx_data !== '0) begin
      errors++; $display("FAIL reset_outputs: got tx=%b arg3=%h expected tx=0 arg3=00 data=0", eth_tx, eth_tx_arg3);
    end
    checks++;
    if ({stats_pkt_in, stats_pkt_out, stats_drop, stats_err, stats_trunc} !== '0) begin
      errors++; $display("FAIL reset_stats: got %h %h %h %h %h expected all 0",
                         stats_pkt_in, stats_pkt_out, stats_drop, stats_err, stats_trunc);
    end
    Rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [511:0] d [3];
    logic [7:0]   exp_arg3 [3];
    do_reset();
    d[0] = {16{32'h1111_0001}}; d[1] = {16{32'h2222_0002}}; d[2] = {16{32'h3333_0003}};
    exp_arg3[0] = 8'h01; exp_arg3[1] = 8'h00; exp_arg3[2] = 8'h16;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, i == 0, i == 2, (i == 2) ? 6'd5 : 6'd0, 1'b0, d[i]);
      checks++;
      if (eth_tx !== 1'b1 || eth_tx_arg3 !== exp_arg3[i] || eth_tx_data !== d[i]) begin
        errors++; $display("FAIL basic_flit%0d: got tx=%b arg3=%h expected tx=1 arg3=%h", i, eth_tx, eth_tx_arg3, exp_arg3[i]);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, '0);
    checks++;
    if (eth_tx !== 1'b0) begin
      errors++; $display("FAIL basic_idle_tx: got %b expected 0", eth_tx);
    end
    checks++;
    if (stats_pkt_out !== 32'd1 || stats_pkt_in !== 32'd1) begin
      errors++; $display("FAIL basic_stats: got in=%0d out=%0d expected in=1 out=1", stats_pkt_in, stats_pkt_out);
    end
  endtask

  task automatic test_drop();
    int ntx;
    do_reset();
    ntx = 0;
    drive(1'b1, 1'b1, 1'b0, 6'd0, 1'b1, {16{32'hDEAD_0000}});
    if (eth_tx) ntx++;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, i == 3, 6'd0, 1'b0, {16{32'hDEAD_0001}});
      if (eth_tx) ntx++;
    end
    checks++;
    if (ntx != 0 || stats_drop !== 32'd1) begin
      errors++; $display("FAIL drop_pkt: got tx_count=%0d drop=%0d expected tx_count=0 drop=1", ntx, stats_drop);
    end
    // Next packet goes out whole even though txFull rises mid-packet.
    drive(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, {16{32'hBEEF_0000}});
    checks++;
    if (eth_tx !== 1'b1 || eth_tx_arg3 !== 8'h01) begin
      errors++; $display("FAIL drop_next_sop: got tx=%b arg3=%h expected tx=1 arg3=01", eth_tx, eth_tx_arg3);
    end
    drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b1, {16{32'hBEEF_0001}});
    checks++;
    if (eth_tx !== 1'b1 || eth_tx_arg3 !== 8'h00) begin
      errors++; $display("FAIL drop_midfull: got tx=%b arg3=%h expected tx=1 arg3=00", eth_tx, eth_tx_arg3);
    end
    drive(1'b1, 1'b0, 1'b1, 6'd2, 1'b1, {16{32'hBEEF_0002}});
    checks++;
    if (eth_tx !== 1'b1 || eth_tx_arg3 !== 8'h0A) begin
      errors++; $display("FAIL drop_next_eop: got tx=%b arg3=%h expected tx=1 arg3=0a", eth_tx, eth_tx_arg3);
    end
    checks++;
    if (stats_drop !== 32'd1 || stats_pkt_out !== 32'd1 || stats_pkt_in !== 32'd2 || stats_err !== 32'd0) begin
      errors++; $display("FAIL drop_stats: got drop=%0d out=%0d in=%0d err=%0d expected 1 1 2 0",
                         stats_drop, stats_pkt_out, stats_pkt_in, stats_err);
    end
  endtask

  task automatic test_resync();
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 6'd0, 1'b1, {16{32'h5555_0000}});
    drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, {16{32'h5555_0001}});
    checks++;
    if (eth_tx !== 1'b0) begin
      errors++; $display("FAIL resync_dropbody: got tx=%b expected 0", eth_tx);
    end
    drive(1'b1, 1'b1, 1'b1, 6'd1, 1'b0, {16{32'h6666_0000}});
    checks++;
    if (eth_tx !== 1'b1 || eth_tx_arg3 !== 8'h07 || stats_err !== 32'd0) begin
      errors++; $display("FAIL resync_sop: got tx=%b arg3=%h err=%0d expected tx=1 arg3=07 err=0", eth_tx, eth_tx_arg3, stats_err);
    end
  endtask

  task automatic test_orphan();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, {16{32'h0BAD_0000}});
    checks++;
    if (eth_tx !== 1'b0 || stats_err !== 32'd1) begin
      errors++; $display("FAIL orphan: got tx=%b err=%0d expected tx=0 err=1", eth_tx, stats_err);
    end
    drive(1'b1, 1'b1, 1'b1, 6'd3, 1'b0, {16{32'h600D_0000}});
    checks++;
    if (eth_tx !== 1'b1 || eth_tx_arg3 !== 8'h0F || eth_tx_data !== {16{32'h600D_0000}}) begin
      errors++; $display("FAIL orphan_single: got tx=%b arg3=%h expected tx=1 arg3=0f", eth_tx, eth_tx_arg3);
    end
    checks++;
    if (stats_err !== 32'd1 || stats_pkt_out !== 32'd1) begin
      errors++; $display("FAIL orphan_stats: got err=%0d out=%0d expected err=1 out=1", stats_err, stats_pkt_out);
    end
  endtask

  task automatic test_missing_eop();
    logic exp_tx [5];
    logic sop_v [5];
    logic eop_v [5];
    exp_tx = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    sop_v  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    eop_v  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, sop_v[i], eop_v[i], (i == 2) ? 6'd7 : 6'd0, 1'b0, {16{32'h7000_0000 | i}});
      checks++;
      if (eth_tx !== exp_tx[i]) begin
        errors++; $display("FAIL missing_eop_tx%0d: got %b expected %b", i, eth_tx, exp_tx[i]);
      end
      if (i == 2) begin
        checks++;
        if (eth_tx_arg3 !== 8'h02) begin
          errors++; $display("FAIL missing_eop_close: got arg3=%h expected 02", eth_tx_arg3);
        end
      end
    end
    checks++;
    if (stats_err !== 32'd1 || stats_pkt_in !== 32'd2 || stats_pkt_out !== 32'd1) begin
      errors++; $display("FAIL missing_eop_stats: got err=%0d in=%0d out=%0d expected 1 2 1",
                         stats_err, stats_pkt_in, stats_pkt_out);
    end
  endtask

  task automatic test_length(input int nflits, input int exp_tx_cnt, input logic [7:0] exp_arg3_24,
                             input logic [31:0] exp_trunc);
    int ntx;
    do_reset();
    ntx = 0;
    for (int i = 1; i <= nflits; i++) begin
      drive(1'b1, i == 1, i == nflits, (i == 24) ? 6'd9 : ((i == nflits) ? 6'd4 : 6'd0), 1'b0,
            {16{32'hC000_0000 | i}});
      if (eth_tx) ntx++;
      if (i == 24) begin
        checks++;
        if (eth_tx !== 1'b1 || eth_tx_arg3 !== exp_arg3_24) begin
          errors++; $display("FAIL len%0d_flit24: got tx=%b arg3=%h expected tx=1 arg3=%h",
                             nflits, eth_tx, eth_tx_arg3, exp_arg3_24);
        end
      end
    end
    checks++;
    if (ntx != exp_tx_cnt || stats_trunc !== exp_trunc || stats_pkt_out !== 32'd1) begin
      errors++; $display("FAIL len%0d_total: got tx_count=%0d trunc=%0d out=%0d expected %0d %0d 1",
                         nflits, ntx, stats_trunc, stats_pkt_out, exp_tx_cnt, exp_trunc);
    end
  endtask

  task automatic test_reset_midpkt();
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, {16{32'hAAAA_0001}});
    checks++;
    if (eth_tx !== 1'b1 || stats_pkt_in !== 32'd1) begin
      errors++; $display("FAIL rstmid_flit1: got tx=%b in=%0d expected tx=1 in=1", eth_tx, stats_pkt_in);
    end
    in_valid = 1'b1; in_sop = 1'b0; in_eop = 1'b0; in_data = {16{32'hAAAA_0002}};
    #2;
    Rst = 1'b1;
    #1;
    checks++;
    if (eth_tx !== 1'b0 || stats_pkt_in !== 32'd0 || eth_tx_arg3 !== 8'h00) begin
      errors++; $display("FAIL rstmid_async: got tx=%b in=%0d arg3=%h expected tx=0 in=0 arg3=00",
                         eth_tx, stats_pkt_in, eth_tx_arg3);
    end
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    for (int i = 3; i <= 5; i++) begin
      drive(1'b1, 1'b0, i == 5, 6'd0, 1'b0, {16{32'hAAAA_0000 | i}});
      checks++;
      if (eth_tx !== 1'b0) begin
        errors++; $display("FAIL rstmid_orphan%0d: got tx=%b expected 0", i, eth_tx);
      end
    end
    checks++;
    if (stats_err !== 32'd3 || stats_pkt_out !== 32'd0) begin
      errors++; $display("FAIL rstmid_stats: got err=%0d out=%0d expected err=3 out=0", stats_err, stats_pkt_out);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b1, 6'(i), 1'b0, {16{32'hB2B0_0000 | i}});
      checks++;
      if (eth_tx !== 1'b1 || eth_tx_arg3 !== {6'(i), 2'b11}) begin
        errors++; $display("FAIL b2b_%0d: got tx=%b arg3=%h expected tx=1 arg3=%h", i, eth_tx, eth_tx_arg3, {6'(i), 2'b11});
      end
    end
    checks++;
    if (stats_pkt_out !== 32'd3 || stats_pkt_in !== 32'd3) begin
      errors++; $display("FAIL b2b_stats: got in=%0d out=%0d expected 3 3", stats_pkt_in, stats_pkt_out);
    end
  endtask

  initial begin
    Rst = 1'b1;
    in_valid = 0; in_sop = 0; in_eop = 0; in_empty = 0; eth_tx_full = 0; in_data = '0;
    test_reset();
    test_basic();
    test_drop();
    test_resync();
    test_orphan();
    test_missing_eop();
`ifdef ETH_INGRESS_LEN_CHECK_EN
    test_length(30, 24, 8'h02, 32'd1);
`else
    test_length(30, 30, 8'h24, 32'd0);
`endif
    test_length(24, 24, 8'h26, 32'd0);
    test_reset_midpkt();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
